// File: rtl/clock_ref_select_pkg.sv
// Shared FSM state type and width helpers for the reference selector.
package clock_ref_select_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SWITCH,
    ST_WAIT_LOCK,
    ST_RUN,
    ST_EVAL
  } state_e;

  function automatic int cnt_w(input int expect_edges);
    return $clog2(2 * expect_edges + 1);
  endfunction

  function automatic int sel_w(input int ch_count);
    return (ch_count > 1) ? $clog2(ch_count) : 1;
  endfunction

endpackage

// File: rtl/clock_ref_select_meter.sv
// One reference channel: 2-flop sync, rising-edge count per window, qualification.
// CLOCK_REF_SELECT_FREQ_REPORT_EN adds the last-window count output.
module clock_ref_meter
  import clock_ref_select_pkg::*;
#(
  parameter int EXPECT_EDGES = 1000,
  parameter int TOL_EDGES    = 2,
  parameter int QUAL_WINDOWS = 4,
  localparam int CNT_W       = cnt_w(EXPECT_EDGES),
  localparam int GW          = $clog2(QUAL_WINDOWS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ref_i,
  input  logic             win_end_i,
  input  logic             clr_i,
  output logic             good_o
`ifdef CLOCK_REF_SELECT_FREQ_REPORT_EN
  ,
  output logic [CNT_W-1:0] last_o
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2 * EXPECT_EDGES);
  localparam logic [GW-1:0]    QMAX    = GW'(QUAL_WINDOWS);
  localparam int               LO      = EXPECT_EDGES - TOL_EDGES;
  localparam int               HI      = EXPECT_EDGES + TOL_EDGES;

  // [1:0] synchroniser, [2] previous synced value for edge detect
  logic [2:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic             edge_s, win_ok;

  assign edge_s = sync_q[1] & ~sync_q[2];
  assign win_ok = (cnt_q != '0) && (int'(cnt_q) >= LO) && (int'(cnt_q) <= HI);

  always_comb begin
    cnt_d  = cnt_q;
    gcnt_d = gcnt_q;
    if (win_end_i) begin
      // terminal-cycle edge belongs to the next window
      cnt_d = edge_s ? CNT_W'(1) : '0;
      if (win_ok) gcnt_d = (gcnt_q == QMAX) ? gcnt_q : gcnt_q + 1'b1;
      else        gcnt_d = '0;
    end else if (edge_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (clr_i) gcnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      cnt_q  <= '0;
      gcnt_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], ref_i};
      cnt_q  <= cnt_d;
      gcnt_q <= gcnt_d;
    end
  end

  assign good_o = (gcnt_q == QMAX);

`ifdef CLOCK_REF_SELECT_FREQ_REPORT_EN
  logic [CNT_W-1:0] last_q;
  always_ff @(posedge clk_i) begin
    if (rst_i)          last_q <= '0;
    else if (win_end_i) last_q <= cnt_q;
  end
  assign last_o = last_q;
`endif

endmodule

// File: rtl/clock_ref_select.sv
// N-way reference clock selector: window timer, priority pick and PLL switchover FSM.
// CLOCK_REF_SELECT_FREQ_REPORT_EN adds ref_count/ref_count_valid outputs.
module clock_ref_select
  import clock_ref_select_pkg::*;
#(
  parameter int CH_COUNT       = 2,
  parameter int WINDOW_CYCLES  = 25000,
  parameter int EXPECT_EDGES   = 1000,
  parameter int TOL_EDGES      = 2,
  parameter int QUAL_WINDOWS   = 4,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 250000,
  localparam int SEL_W         = sel_w(CH_COUNT),
  localparam int CNT_W         = cnt_w(EXPECT_EDGES)
) (
  input  logic                      clk_250mhz,
  input  logic                      rst_250mhz,
  input  logic [CH_COUNT-1:0]       ref_in,
  input  logic [CH_COUNT-1:0]       ch_enable,
  input  logic                      pll_locked,
  output logic [SEL_W-1:0]          sel,
  output logic                      sel_valid,
  output logic                      pll_reset,
  output logic [CH_COUNT-1:0]       ch_good,
  output logic                      switch_pulse
`ifdef CLOCK_REF_SELECT_FREQ_REPORT_EN
  ,
  output logic [CH_COUNT*CNT_W-1:0] ref_count,
  output logic                      ref_count_valid
`endif
);

  localparam int WW = $clog2(WINDOW_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + PLL_RST_CYCLES + 1);

  logic [WW-1:0]       win_q;
  logic                win_end;
  logic [CH_COUNT-1:0] good_q, clr_vec;
  logic [1:0]          lock_q;
  logic                lock_s;
  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d, tgt;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic                pulse_q, pulse_d, tgt_vld, cur_ok;

  assign win_end = (win_q == WW'(WINDOW_CYCLES - 1));
  assign lock_s  = lock_q[1];

  for (genvar i = 0; i < CH_COUNT; i++) begin : g_meter
    clock_ref_meter #(
      .EXPECT_EDGES (EXPECT_EDGES),
      .TOL_EDGES    (TOL_EDGES),
      .QUAL_WINDOWS (QUAL_WINDOWS)
    ) u_meter (
      .clk_i     (clk_250mhz),
      .rst_i     (rst_250mhz),
      .ref_i     (ref_in[i]),
      .win_end_i (win_end),
      .clr_i     (clr_vec[i]),
      .good_o    (ch_good[i])
`ifdef CLOCK_REF_SELECT_FREQ_REPORT_EN
      ,
      .last_o    (ref_count[i*CNT_W +: CNT_W])
`endif
    );
  end

  // lowest enabled, qualified channel wins
  always_comb begin
    tgt_vld = 1'b0;
    tgt     = '0;
    for (int i = CH_COUNT - 1; i >= 0; i--) begin
      if (good_q[i] && ch_enable[i]) begin
        tgt_vld = 1'b1;
        tgt     = SEL_W'(i);
      end
    end
  end

  assign cur_ok = good_q[sel_q] & ch_enable[sel_q];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    tmr_d   = tmr_q;
    pulse_d = 1'b0;
    clr_vec = '0;
    case (state_q)
      ST_IDLE: if (tgt_vld) begin
        sel_d   = tgt;
        pulse_d = 1'b1;
        tmr_d   = '0;
        state_d = ST_SWITCH;
      end
      ST_SWITCH: begin
        if (tmr_q == TW'(PLL_RST_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = ST_WAIT_LOCK;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        tmr_d = tmr_q + 1'b1;
        if (lock_s) state_d = ST_RUN;
        else if (!cur_ok) state_d = ST_EVAL;
        else if (tmr_q == TW'(LOCK_TIMEOUT - 1)) begin
          // a channel that never locks must requalify before retry
          clr_vec[sel_q] = 1'b1;
          state_d        = ST_EVAL;
        end
      end
      ST_RUN: begin
        if (!tgt_vld || (tgt != sel_q)) state_d = ST_EVAL;
        else if (!lock_s) begin
          tmr_d   = '0;
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_EVAL: begin
        tmr_d = '0;
        if (!tgt_vld) state_d = ST_IDLE;
        else if (tgt != sel_q) begin
          sel_d   = tgt;
          pulse_d = 1'b1;
          state_d = ST_SWITCH;
        end else begin
          state_d = ST_WAIT_LOCK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_250mhz) begin
    if (rst_250mhz) begin
      win_q   <= '0;
      good_q  <= '0;
      lock_q  <= '0;
      state_q <= ST_IDLE;
      sel_q   <= '0;
      tmr_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      win_q   <= win_end ? '0 : win_q + 1'b1;
      good_q  <= ch_good;
      lock_q  <= {lock_q[0], pll_locked};
      state_q <= state_d;
      sel_q   <= sel_d;
      tmr_q   <= tmr_d;
      pulse_q <= pulse_d;
    end
  end

`ifdef CLOCK_REF_SELECT_FREQ_REPORT_EN
  logic rcv_q;
  always_ff @(posedge clk_250mhz) begin
    if (rst_250mhz) rcv_q <= 1'b0;
    else            rcv_q <= win_end;
  end
  assign ref_count_valid = rcv_q;
`endif

  assign sel          = sel_q;
  assign sel_valid    = (state_q == ST_RUN) && lock_s;
  assign pll_reset    = (state_q == ST_IDLE) || (state_q == ST_SWITCH);
  assign switch_pulse = pulse_q;

endmodule

// File: tb/tb_clock_ref_select.sv
// Directed bench: table of settle-and-check steps plus hand sequences for
// lock timeout/requalification, PLL reset pulse width and mid-run reset.
module tb_clock_ref_select;

  localparam int CNT_W = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       r0 = 1'b0, r1 = 1'b0;
  logic [1:0] ref_in;
  logic [1:0] ch_enable = 2'b11;
  logic       pll_locked = 1'b0;
  logic       sel;
  logic       sel_valid, pll_reset, switch_pulse;
  logic [1:0] ch_good;
`ifdef CLOCK_REF_SELECT_FREQ_REPORT_EN
  logic [2*CNT_W-1:0] ref_count;
  logic               ref_count_valid;
`endif

  assign ref_in = {r1, r0};

  clock_ref_select #(
    .CH_COUNT(2), .WINDOW_CYCLES(250), .EXPECT_EDGES(10), .TOL_EDGES(1),
    .QUAL_WINDOWS(2), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(100)
  ) dut (
    .clk_250mhz   (clk),
    .rst_250mhz   (rst),
    .ref_in       (ref_in),
    .ch_enable    (ch_enable),
    .pll_locked   (pll_locked),
    .sel          (sel),
    .sel_valid    (sel_valid),
    .pll_reset    (pll_reset),
    .ch_good      (ch_good),
    .switch_pulse (switch_pulse)
`ifdef CLOCK_REF_SELECT_FREQ_REPORT_EN
    ,
    .ref_count       (ref_count),
    .ref_count_valid (ref_count_valid)
`endif
  );

  initial forever #2 clk = ~clk;

  // reference generators, period in clk cycles (0 = dead)
  int p0 = 25, p1 = 0;
  initial begin
    #1;
    forever begin
      if (p0 == 0) begin r0 = 1'b0; #4; end
      else begin r0 = 1'b1; #(p0 * 2); r0 = 1'b0; #(p0 * 2); end
    end
  end
  initial begin
    #1;
    forever begin
      if (p1 == 0) begin r1 = 1'b0; #4; end
      else begin r1 = 1'b1; #(p1 * 2); r1 = 1'b0; #(p1 * 2); end
    end
  end

  // PLL model: locks 20 cycles after reset release, unless lk_en is low
  bit lk_en = 1'b1;
  int lk_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (pll_reset || !lk_en) begin lk_cnt = 0; pll_locked = 1'b0; end
    else if (lk_cnt < 20) lk_cnt++;
    else pll_locked = 1'b1;
  end

  // pulse count and width of the most recent pll_reset high run
  int npulse = 0, hi_run = 0, last_hi = 0;
  initial forever begin
    @(negedge clk);
    if (switch_pulse) npulse++;
    if (pll_reset) hi_run++;
    else if (hi_run != 0) begin last_hi = hi_run; hi_run = 0; end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int         p0, p1;
    logic [1:0] en;
    bit         lk;
    int         cyc;
    int         e_sel, e_vld, e_prst, e_good, e_pulses;
  } step_t;
  step_t tbl[7];

  task automatic run_row(input int i);
    int base;
    p0 = tbl[i].p0; p1 = tbl[i].p1; ch_enable = tbl[i].en; lk_en = tbl[i].lk;
    base = npulse;
    repeat (tbl[i].cyc) @(negedge clk);
    chk($sformatf("r%0d_sel", i), {31'b0, sel}, tbl[i].e_sel);
    chk($sformatf("r%0d_valid", i), {31'b0, sel_valid}, tbl[i].e_vld);
    chk($sformatf("r%0d_pll_reset", i), {31'b0, pll_reset}, tbl[i].e_prst);
    chk($sformatf("r%0d_ch_good", i), {30'b0, ch_good}, tbl[i].e_good);
    chk($sformatf("r%0d_pulses", i), npulse - base, tbl[i].e_pulses);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_sel"}, {31'b0, sel}, 0);
    chk({tag, "_valid"}, {31'b0, sel_valid}, 0);
    chk({tag, "_pll_reset"}, {31'b0, pll_reset}, 1);
    chk({tag, "_ch_good"}, {30'b0, ch_good}, 0);
    chk({tag, "_pulse"}, {31'b0, switch_pulse}, 0);
  endtask

  initial begin
    int n, base;
    //          p0  p1  en    lk  cyc   sel vld prst good pulses
    tbl[0] = '{25,  0, 2'b11, 1,  700,  0,  1,  0,   1,   1}; // ref0 qualifies, locks
    tbl[1] = '{25, 26, 2'b11, 1,  900,  0,  1,  0,   3,   0}; // ref1 good, no switch
    tbl[2] = '{ 0, 26, 2'b11, 1,  750,  1,  1,  0,   2,   1}; // ref0 dies -> ref1
    tbl[3] = '{ 0, 20, 2'b11, 1,  750,  1,  0,  1,   0,   0}; // ref1 too fast -> idle
    tbl[4] = '{ 0, 26, 2'b11, 1,  700,  1,  1,  0,   2,   1}; // lock allowed again
    tbl[5] = '{25, 26, 2'b11, 1, 1000,  0,  1,  0,   3,   1}; // ref0 back -> sel 0
    tbl[6] = '{25, 26, 2'b10, 1,  300,  1,  1,  0,   3,   1}; // ch0 disabled -> sel 1

    repeat (5) @(negedge clk);
    check_reset_state("init");
    rst = 1'b0;

    for (int i = 0; i < 3; i++) run_row(i);
    chk("pll_reset_width", last_hi, 4);
    run_row(3);

    // lock never comes: timeout clears ch1, which must requalify
    p1 = 26; lk_en = 1'b0;
    base = npulse;
    n = 0;
    while (!switch_pulse && n < 2000) begin @(negedge clk); n++; end
    chk("to_pulse_seen", {31'b0, switch_pulse}, 1);
    chk("to_sel", {31'b0, sel}, 1);
    n = 0;
    while (ch_good[1] && n < 300) begin @(negedge clk); n++; end
    chk("to_drop_cycles", n, 104);
    n = 0;
    while (!ch_good[1] && n < 1000) begin @(negedge clk); n++; end
    chk("to_requal_in_range", {31'b0, (n >= 240 && n <= 510)}, 1);
    chk("to_pulses", npulse - base, 1);
    chk("to_valid", {31'b0, sel_valid}, 0);

    for (int i = 4; i < 7; i++) run_row(i);

    // synchronous reset while running on ch1
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("midrst");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
